prog_launcher: RTL

- Host-side initiator for the processor's Start/Ack run handshake. The processor is the responder.
- Accepts a run request carrying a program index, then drives ProgSel and a Start pulse of fixed width.
- Waits for the processor to leave and then re-enter halt (Ack), counting cycles the whole time and enforcing a timeout.
- Reports the cycle count, completion and timeout status back to the host.
- Sits between the test/host sequencer and the TopLevel processor.

---
 rtl/prog_launcher.sv | 138 +++++++++++++
 1 files changed

// File: rtl/prog_launcher.sv
// rtl/prog_launcher.sv - Start/Ack run-handshake initiator; optional ACK_SYNC_EN adds a 2-flop Ack synchronizer.
module prog_launcher #(
    parameter int START_LEN = 2,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 10000,
    parameter int PROG_W    = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic [PROG_W-1:0] prog_id,
    output logic              ready,
    output logic              busy,
    output logic              Start,
    output logic [PROG_W-1:0] ProgSel,
    input  logic              Ack,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycles
);

    localparam int              LEN_W     = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               to_q, to_d;
    logic [PROG_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ack_use;

`ifdef ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) ack_sync_q <= 2'b00;
        else        ack_sync_q <= {ack_sync_q[0], Ack};
    end

    assign ack_use = ack_sync_q[1];

    // Remove the synchronizer latency so results match the direct-Ack build
    function automatic logic [CNT_W-1:0] report_cnt(input logic [CNT_W-1:0] raw);
        return (raw >= CNT_W'(2)) ? raw - CNT_W'(2) : '0;
    endfunction
`else
    assign ack_use = Ack;

    function automatic logic [CNT_W-1:0] report_cnt(input logic [CNT_W-1:0] raw);
        return raw;
    endfunction
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            to_q     <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            to_q     <= to_d;
            sel_q    <= sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        to_d     = to_q;
        sel_d    = sel_q;
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = LAUNCH;
                    start_d  = 1'b1;
                    len_d    = '0;
                    cnt_d    = '0;
                    cycles_d = '0;
                    to_d     = 1'b0;
                    sel_d    = prog_id;
                end
            end
            LAUNCH: begin
                if (len_q == LEN_LAST) begin
                    state_d = ARM;
                    start_d = 1'b0;
                end else begin
                    len_d = len_q + 1'b1;
                end
            end
            ARM, RUN: begin
                cnt_d = cnt_inc;
                // A completing Ack takes priority over a simultaneous timeout
                if (state_q == RUN && ack_use) begin
                    state_d  = DONE;
                    cycles_d = report_cnt(cnt_inc);
                end else begin
                    if (state_q == ARM && !ack_use) state_d = RUN;
                    if (cnt_inc == TMO) begin
                        state_d  = DONE;
                        to_d     = 1'b1;
                        cycles_d = TMO;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign busy      = !ready;
    assign done      = (state_q == DONE);
    assign Start     = start_q;
    assign ProgSel   = sel_q;
    assign timed_out = to_q;
    assign cycles    = cycles_q;

endmodule
